// File: rtl/chirp_pulse_responder_if.sv
// Controller <-> chirp generator handshake plus the phase stream towards the DAC stage.
// No logic inside; signal bundle only.
// Flow control is the ready/active/done handshake; the phase stream has no backpressure.
interface chirp_pulse_responder_if #(
  parameter int PHASE_W = 32
);
  logic               dac_locked;
  logic               chirp_init;
  logic               chirp_enable;
  logic [31:0]        chirp_time_int;
  logic [PHASE_W-1:0] chirp_freq_offset;
  logic [PHASE_W-1:0] chirp_tuning_word;
  logic               chirp_ready;
  logic               chirp_active;
  logic               chirp_done;
  logic               chirp_aborted;
  logic               dac_valid;
  logic [PHASE_W-1:0] dac_phase;
  logic [31:0]        sample_count;

  // Controller side: drives requests and programming, observes status and phase.
  modport master (
    output dac_locked, chirp_init, chirp_enable,
    output chirp_time_int, chirp_freq_offset, chirp_tuning_word,
    input  chirp_ready, chirp_active, chirp_done, chirp_aborted,
    input  dac_valid, dac_phase, sample_count
  );

  // Chirp generator side.
  modport slave (
    input  dac_locked, chirp_init, chirp_enable,
    input  chirp_time_int, chirp_freq_offset, chirp_tuning_word,
    output chirp_ready, chirp_active, chirp_done, chirp_aborted,
    output dac_valid, dac_phase, sample_count
  );
endinterface

// File: rtl/chirp_pulse_responder.sv
// Linear-FM chirp generator: on accepted init emits L phase samples, then pulses done.
// Latency: first sample (phase 0) one cycle after the accepting edge; done one cycle after last sample.
// No backpressure on the phase stream; init is only taken while chirp_ready is high, else ignored.
module chirp_pulse_responder #(
  parameter int PHASE_W      = 32,
  parameter int SETUP_CYCLES = 16
) (
  input logic                    aclk,
  input logic                    areset,
  chirp_pulse_responder_if.slave bus
);

  typedef enum logic [1:0] {SETUP, READY, RUN, DONE} state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         setup_cnt;
  logic [31:0]        len;
  logic [31:0]        sample_cnt;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] freq;
  logic [PHASE_W-1:0] dfreq;
  logic               aborted;

  logic               setup_done;
  logic               accept;
  logic               step;
  logic               advance;
  logic               abort;
  logic               ready_c;
  logic               active_c;
  logic               done_c;

  assign setup_done = (setup_cnt == SETUP_LAST);

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state <= SETUP;
    else        state <= state_nxt;
  end

  // Next-state and Moore status decode; lock loss outranks enable loss outranks completion.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    advance   = 1'b0;
    abort     = 1'b0;
    ready_c   = 1'b0;
    active_c  = 1'b0;
    done_c    = 1'b0;
    case (state)
      SETUP: begin
        if (bus.dac_locked && setup_done) state_nxt = READY;
      end
      READY: begin
        ready_c = 1'b1;
        if (!bus.dac_locked) begin
          state_nxt = SETUP;
        end else if (bus.chirp_init && bus.chirp_enable) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        active_c = 1'b1;
        step     = 1'b1;
        if (!bus.dac_locked) begin
          abort     = 1'b1;
          state_nxt = SETUP;
        end else if (!bus.chirp_enable) begin
          abort     = 1'b1;
          state_nxt = READY;
        end else if (sample_cnt + 32'd1 == len) begin
          state_nxt = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      DONE: begin
        done_c = 1'b1;
        if (!bus.dac_locked) state_nxt = SETUP;
        else                 state_nxt = READY;
      end
      default: state_nxt = SETUP;
    endcase
  end

  // Lock qualification counter: restarts on every entry to SETUP and whenever lock drops.
  always_ff @(posedge aclk) begin
    if (areset) begin
      setup_cnt <= 8'd0;
    end else if (state != SETUP) begin
      if (state_nxt == SETUP) setup_cnt <= 8'd0;
    end else if (!bus.dac_locked) begin
      setup_cnt <= 8'd0;
    end else if (!setup_done) begin
      setup_cnt <= setup_cnt + 8'd1;
    end
  end

  // Chirp datapath; phase only advances while another sample follows, so it holds the last one.
  always_ff @(posedge aclk) begin
    if (areset) begin
      len        <= 32'd0;
      sample_cnt <= 32'd0;
      phase      <= '0;
      freq       <= '0;
      dfreq      <= '0;
      aborted    <= 1'b0;
    end else begin
      aborted <= abort;
      if (accept) begin
        len        <= (bus.chirp_time_int == 32'd0) ? 32'd1 : bus.chirp_time_int;
        sample_cnt <= 32'd0;
        phase      <= '0;
        freq       <= bus.chirp_freq_offset;
        dfreq      <= bus.chirp_tuning_word;
      end else begin
        if (step)    sample_cnt <= sample_cnt + 32'd1;
        if (advance) begin
          phase <= phase + freq;
          freq  <= freq + dfreq;
        end
      end
    end
  end

  assign bus.chirp_ready   = ready_c;
  assign bus.chirp_active  = active_c;
  assign bus.dac_valid     = active_c;
  assign bus.chirp_done    = done_c;
  assign bus.chirp_aborted = aborted;
  assign bus.dac_phase     = phase;
  assign bus.sample_count  = sample_cnt;

endmodule

// File: tb/tb_chirp_pulse_responder.sv
// Directed bench for chirp_pulse_responder: table of chirps plus abort/reset/misuse sequences.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// The DUT never stalls the bench; every wait on ready is bounded.
module tb_chirp_pulse_responder;

  localparam int PHASE_W      = 32;
  localparam int SETUP_CYCLES = 16;

  logic aclk;
  logic areset;
  int   total;
  int   bad;

  chirp_pulse_responder_if #(.PHASE_W(PHASE_W)) bus ();

  chirp_pulse_responder #(
    .PHASE_W     (PHASE_W),
    .SETUP_CYCLES(SETUP_CYCLES)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0]          len;
    logic [31:0]          f0;
    logic [31:0]          df;
    int                   n;
    logic [0:7][31:0]     ph;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts edges until chirp_ready is seen, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (bus.chirp_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  // Runs one table chirp; with misuse set, also pokes init during RUN and DONE.
  task automatic run_chirp(input vec_t v, input bit misuse);
    bus.chirp_time_int    = v.len;
    bus.chirp_freq_offset = v.f0;
    bus.chirp_tuning_word = v.df;
    bus.chirp_enable      = 1'b1;
    bus.chirp_init        = 1'b1;
    tick();
    bus.chirp_init = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      check("active", 64'(bus.chirp_active), 64'd1);
      check("valid", 64'(bus.dac_valid), 64'd1);
      check("ready_in_run", 64'(bus.chirp_ready), 64'd0);
      check("phase", 64'(bus.dac_phase), 64'(v.ph[k]));
      if (misuse && k == 2) begin
        bus.chirp_init        = 1'b1;
        bus.chirp_time_int    = 32'd2;
        bus.chirp_freq_offset = 32'hDEAD_BEEF;
        bus.chirp_tuning_word = 32'h1111_1111;
      end else begin
        bus.chirp_init = 1'b0;
      end
      tick();
    end
    check("done", 64'(bus.chirp_done), 64'd1);
    check("active_at_done", 64'(bus.chirp_active), 64'd0);
    check("ready_at_done", 64'(bus.chirp_ready), 64'd0);
    check("aborted_at_done", 64'(bus.chirp_aborted), 64'd0);
    check("sample_count", 64'(bus.sample_count), 64'(v.n));
    check("phase_hold", 64'(bus.dac_phase), 64'(v.ph[v.n-1]));
    bus.chirp_init = misuse;
    tick();
    bus.chirp_init = 1'b0;
    check("ready_after_done", 64'(bus.chirp_ready), 64'd1);
    check("done_one_cycle", 64'(bus.chirp_done), 64'd0);
    check("no_accept_in_done", 64'(bus.chirp_active), 64'd0);
  endtask

  // Accepts an L=100 chirp and stops in its active cycle number 'cyc'.
  task automatic start_long(input int cyc);
    bus.chirp_time_int    = 32'd100;
    bus.chirp_freq_offset = 32'h100;
    bus.chirp_tuning_word = 32'h10;
    bus.chirp_enable      = 1'b1;
    bus.chirp_init        = 1'b1;
    tick();
    bus.chirp_init = 1'b0;
    repeat (cyc - 1) tick();
    check("long_active", 64'(bus.chirp_active), 64'd1);
  endtask

  int n;

  initial begin
    total = 0;
    bad   = 0;

    vecs[0] = '{32'd8, 32'h100, 32'h10, 8,
                {32'h0, 32'h100, 32'h210, 32'h330, 32'h460, 32'h5A0, 32'h6F0, 32'h850}};
    vecs[1] = '{32'd4, 32'hFFFF_FFF0, 32'h0, 4,
                {32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'hFFFF_FFD0, 32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[2] = '{32'd0, 32'h1234, 32'h5, 1,
                {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[3] = '{32'd3, 32'h1, 32'h2, 3,
                {32'h0, 32'h1, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[4] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 5,
                {32'h0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};

    areset                = 1'b1;
    bus.dac_locked        = 1'b1;
    bus.chirp_init        = 1'b0;
    bus.chirp_enable      = 1'b0;
    bus.chirp_time_int    = 32'd0;
    bus.chirp_freq_offset = '0;
    bus.chirp_tuning_word = '0;

    // Power-up
    repeat (3) tick();
    check("rst_ready", 64'(bus.chirp_ready), 64'd0);
    check("rst_active", 64'(bus.chirp_active), 64'd0);
    check("rst_done", 64'(bus.chirp_done), 64'd0);
    check("rst_aborted", 64'(bus.chirp_aborted), 64'd0);
    check("rst_phase", 64'(bus.dac_phase), 64'd0);
    check("rst_count", 64'(bus.sample_count), 64'd0);
    areset = 1'b0;
    wait_ready(n);
    check("powerup_setup_cycles", 64'(n), 64'(SETUP_CYCLES));

    // Init without enable is ignored
    bus.chirp_init = 1'b1;
    tick();
    bus.chirp_init = 1'b0;
    check("init_no_enable_ready", 64'(bus.chirp_ready), 64'd1);
    check("init_no_enable_active", 64'(bus.chirp_active), 64'd0);

    // Table of chirps, back-to-back at N+L+2
    for (int i = 0; i < 5; i++) run_chirp(vecs[i], (i == 0));

    // Enable abort at the 10th active cycle
    start_long(10);
    bus.chirp_enable = 1'b0;
    tick();
    check("en_abort_aborted", 64'(bus.chirp_aborted), 64'd1);
    check("en_abort_done", 64'(bus.chirp_done), 64'd0);
    check("en_abort_active", 64'(bus.chirp_active), 64'd0);
    check("en_abort_ready", 64'(bus.chirp_ready), 64'd1);
    check("en_abort_count", 64'(bus.sample_count), 64'd10);
    check("en_abort_phase", 64'(bus.dac_phase), 64'h0B40);
    tick();
    check("en_abort_pulse_len", 64'(bus.chirp_aborted), 64'd0);
    check("en_abort_ready2", 64'(bus.chirp_ready), 64'd1);

    // Lock-loss abort at the 10th active cycle, then init held during SETUP
    start_long(10);
    bus.dac_locked = 1'b0;
    tick();
    check("lock_abort_aborted", 64'(bus.chirp_aborted), 64'd1);
    check("lock_abort_done", 64'(bus.chirp_done), 64'd0);
    check("lock_abort_active", 64'(bus.chirp_active), 64'd0);
    check("lock_abort_ready", 64'(bus.chirp_ready), 64'd0);
    tick();
    check("lock_abort_pulse_len", 64'(bus.chirp_aborted), 64'd0);
    bus.chirp_init   = 1'b1;
    bus.chirp_enable = 1'b1;
    bus.dac_locked   = 1'b1;
    wait_ready(n);
    check("lock_requal_cycles", 64'(n), 64'(SETUP_CYCLES));
    check("setup_init_ignored", 64'(bus.chirp_active), 64'd0);
    check("setup_count_held", 64'(bus.sample_count), 64'd10);
    bus.chirp_init = 1'b0;

    // Lock loss in READY
    bus.dac_locked = 1'b0;
    tick();
    check("ready_lock_loss", 64'(bus.chirp_ready), 64'd0);
    check("ready_lock_loss_abort", 64'(bus.chirp_aborted), 64'd0);
    bus.dac_locked = 1'b1;
    wait_ready(n);
    check("ready_lock_requal", 64'(n), 64'(SETUP_CYCLES));

    // Reset at the 5th active cycle
    start_long(5);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("midrst_active", 64'(bus.chirp_active), 64'd0);
    check("midrst_ready", 64'(bus.chirp_ready), 64'd0);
    check("midrst_done", 64'(bus.chirp_done), 64'd0);
    check("midrst_aborted", 64'(bus.chirp_aborted), 64'd0);
    check("midrst_phase", 64'(bus.dac_phase), 64'd0);
    check("midrst_count", 64'(bus.sample_count), 64'd0);
    wait_ready(n);
    check("midrst_requal", 64'(n), 64'(SETUP_CYCLES));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
